mem_stage_lsu: RTL and testbench

//   MEM-stage load/store unit of the 5-stage RISC-V pipeline; sole producer of the read_data_in and

---
 rtl/pl_pkg.sv | 31 +++
 rtl/lsu_align.sv | 70 +++++++
 rtl/mem_stage_lsu.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pl_pkg
// Brief    : Shared pipeline definitions: funct3 load/store encodings, LSU state.
// Revision : 1.0
// ============================================================================
package pl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Unsigned variants are load-only; everything outside the five encodings is illegal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational alignment check, store lane steering and load extract/extend.
// Revision : 1.0
// ============================================================================
module lsu_align
  import pl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] rdata,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic        size_ok;
  logic [15:0] lane_half;

  always_comb begin
    size_ok = 1'b0;
    case (funct3[1:0])
      2'b00:   size_ok = 1'b1;
      2'b01:   size_ok = ~addr_lo[0];
      2'b10:   size_ok = (addr_lo == 2'b00);
      default: size_ok = 1'b0;
    endcase
    aligned = f3_legal(funct3, is_store) & size_ok;
  end

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before sign/zero extension.
  always_comb begin
    lane_half = 16'(rdata >> {ld_lane, 3'b000});
    load_data = rdata;
    case (ld_funct3)
      F3_B:    load_data = {{24{lane_half[7]}}, lane_half[7:0]};
      F3_BU:   load_data = {24'd0, lane_half[7:0]};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'd0, lane_half};
      default: load_data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM-stage load/store unit: data-memory req/ack bus, load formatting, pipeline stall.
// Revision : 1.0
// ============================================================================
module mem_stage_lsu
  import pl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] read_data,
  output logic        stall_req,
  output logic        misalign,
  output logic        bus_err
);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [31:0]       dm_addr_q, dm_addr_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [1:0]        ld_lane_q, ld_lane_d;
  logic              flushed_q, flushed_d;

  logic              access;
  logic              aligned;
  logic              stall_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       load_c;

  assign access = ex_valid & (mem_read | mem_write) & ~flush;

  // Load formatting uses the captured funct3/lane so the result does not depend
  // on what the EX/MEM register presents when the ack finally arrives.
  lsu_align u_align (
    .funct3    (funct3),
    .addr_lo   (addr[1:0]),
    .is_store  (mem_write),
    .wdata     (wdata),
    .ld_funct3 (ld_funct3_q),
    .ld_lane   (ld_lane_q),
    .rdata     (dm_rdata),
    .aligned   (aligned),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .load_data (load_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_be_d     = dm_be_q;
    dm_wdata_d  = dm_wdata_q;
    read_data_d = read_data_q;
    ld_funct3_d = ld_funct3_q;
    ld_lane_d   = ld_lane_q;
    flushed_d   = flushed_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    stall_c     = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (access) begin
          if (aligned) begin
            dm_req_d    = 1'b1;
            dm_we_d     = mem_write;
            dm_addr_d   = {addr[31:2], 2'b00};
            dm_be_d     = be_c;
            dm_wdata_d  = wdata_c;
            ld_funct3_d = funct3;
            ld_lane_d   = addr[1:0];
            cnt_d       = '0;
            flushed_d   = 1'b0;
            stall_c     = 1'b1;
            state_d     = LSU_WAIT;
          end else begin
            misalign_d  = 1'b1;
          end
        end
      end

      LSU_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (flush) begin
          flushed_d = 1'b1;
        end
        // A killed access still has to finish on the bus; only its result is dropped.
        if (dm_ack) begin
          dm_req_d = 1'b0;
          if (flushed_q || flush) begin
            state_d = LSU_IDLE;
          end else begin
            if (!dm_we_q) begin
              read_data_d = load_c;
            end
            state_d = LSU_DONE;
          end
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          dm_req_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = LSU_IDLE;
        end
      end

      LSU_DONE: begin
        state_d = LSU_IDLE;
      end

      default: begin
        state_d  = LSU_IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_be_q     <= 4'd0;
      dm_wdata_q  <= 32'd0;
      read_data_q <= 32'd0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      ld_funct3_q <= 3'd0;
      ld_lane_q   <= 2'd0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_be_q     <= dm_be_d;
      dm_wdata_q  <= dm_wdata_d;
      read_data_q <= read_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      ld_funct3_q <= ld_funct3_d;
      ld_lane_q   <= ld_lane_d;
      flushed_q   <= flushed_d;
    end
  end

  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_be     = dm_be_q;
  assign dm_wdata  = dm_wdata_q;
  assign read_data = read_data_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
  assign stall_req = rst & stall_c;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Self-checking bench for mem_stage_lsu: vector table plus bus corner sequences.
// Revision : 1.0
// ============================================================================
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'd0;
  logic        dm_req, dm_we, stall_req, misalign, bus_err;
  logic [31:0] dm_addr, dm_wdata, read_data;
  logic [3:0]  dm_be;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .read_data(read_data), .stall_req(stall_req),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rd;
    logic        mis;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdat, input int dly,
                              input logic [3:0] be, input logic [31:0] wrep,
                              input logic [31:0] rd, input logic mis);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat; v.dly = dly;
    v.be = be; v.wrep = wrep; v.rd = rd; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    ex_valid  = 1'b1;
    mem_read  = ~st;
    mem_write = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  task automatic idle_inputs;
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   stalls;
    drive(v.st, v.f3, v.addr, v.wdata);
    exp_q.push_back(v);
    #1;
    if (v.mis) begin
      chk("mis_no_stall", stall_req, 0);
      tick;
      e = exp_q.pop_front();
      chk("misalign_pulse", misalign, 1);
      chk("mis_no_req", dm_req, 0);
      chk("mis_rd_hold", read_data, e.rd);
      idle_inputs();
      tick;
      chk("misalign_clear", misalign, 0);
    end else begin
      stalls = stall_req ? 1 : 0;
      tick;
      e = exp_q.pop_front();
      chk("dm_req_issue", dm_req, 1);
      chk("dm_addr", dm_addr, {e.addr[31:2], 2'b00});
      chk("dm_be", dm_be, e.be);
      chk("dm_we", dm_we, e.st);
      if (e.st) chk("dm_wdata", dm_wdata, e.wrep);
      for (int k = 1; k <= v.dly; k++) begin
        if (k == v.dly) begin
          dm_ack   = 1'b1;
          dm_rdata = v.rdata;
        end
        if (stall_req) stalls++;
        tick;
        dm_ack = 1'b0;
      end
      chk("dm_req_drop", dm_req, 0);
      chk("done_no_stall", stall_req, 0);
      chk("read_data", read_data, e.rd);
      chk("stall_cycles", stalls, v.dly + 1);
      idle_inputs();
      tick;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stalls;
    logic seen;

    vecs[0]  = mk(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
    vecs[1]  = mk(0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 0);
    vecs[2]  = mk(0, 3'b100, 32'h103, 32'h0,        32'h80112233, 2, 4'b1000, 32'h0,        32'h00000080, 0);
    vecs[3]  = mk(0, 3'b101, 32'h102, 32'h0,        32'h80112233, 1, 4'b1100, 32'h0,        32'h00008011, 0);
    vecs[4]  = mk(0, 3'b001, 32'h100, 32'h0,        32'h0000F00D, 2, 4'b0011, 32'h0,        32'hFFFFF00D, 0);
    vecs[5]  = mk(1, 3'b000, 32'h201, 32'h000000A5, 32'hDEADDEAD, 1, 4'b0010, 32'hA5A5A5A5, 32'hFFFFF00D, 0);
    vecs[6]  = mk(1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0,        2, 4'b1100, 32'hBEEFBEEF, 32'hFFFFF00D, 0);
    vecs[7]  = mk(1, 3'b010, 32'h204, 32'h12345678, 32'h0,        1, 4'b1111, 32'h12345678, 32'hFFFFF00D, 0);
    vecs[8]  = mk(0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'hFFFFF00D, 1);
    vecs[9]  = mk(0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'hFFFFF00D, 1);
    vecs[10] = mk(1, 3'b010, 32'h206, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'hFFFFF00D, 1);
    vecs[11] = mk(1, 3'b100, 32'h200, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'hFFFFF00D, 1);
    vecs[12] = mk(0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 4'b0010, 32'h0,        32'h0000007F, 0);

    // Reset state
    tick;
    chk("rst_dm_req", dm_req, 0);
    chk("rst_dm_be", dm_be, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 1'b1;
    tick;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Ack while idle must be ignored
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFEF00D;
    tick;
    dm_ack = 1'b0;
    chk("idle_ack_rd", read_data, 32'h0000007F);
    chk("idle_ack_req", dm_req, 0);

    // Timeout: no ack ever
    drive(0, 3'b010, 32'h300, 32'h0);
    #1;
    stalls = stall_req ? 1 : 0;
    tick;
    chk("to_req", dm_req, 1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (stall_req) stalls++;
      tick;
      if (bus_err) seen = 1'b1;
    end
    chk("to_bus_err_pulse", seen, 1);
    chk("to_req_drop", dm_req, 0);
    idle_inputs();
    #1;
    chk("to_stall_release", stall_req, 0);
    chk("to_stall_cycles", stalls, TIMEOUT + 1);
    chk("to_rd_hold", read_data, 32'h0000007F);
    tick;
    chk("to_bus_err_clear", bus_err, 0);

    // Flush during WAIT: ack data dropped, FSM returns to IDLE without a DONE cycle
    drive(0, 3'b010, 32'h400, 32'h0);
    #1;
    tick;
    chk("fl_req", dm_req, 1);
    flush = 1'b1;
    #1;
    chk("fl_stall_held", stall_req, 1);
    tick;
    flush = 1'b0;
    chk("fl_stall_after", stall_req, 1);
    dm_ack   = 1'b1;
    dm_rdata = 32'h12345678;
    tick;
    dm_ack = 1'b0;
    chk("fl_req_drop", dm_req, 0);
    chk("fl_rd_hold", read_data, 32'h0000007F);
    chk("fl_no_done", stall_req, 1);
    tick;
    chk("fl_reissue", dm_req, 1);
    dm_ack   = 1'b1;
    dm_rdata = 32'h0BADF00D;
    tick;
    dm_ack = 1'b0;
    chk("fl_next_rd", read_data, 32'h0BADF00D);
    idle_inputs();
    tick;

    // Asynchronous reset in the middle of WAIT
    drive(0, 3'b010, 32'h500, 32'h0);
    #1;
    tick;
    chk("rw_req", dm_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_req_drop", dm_req, 0);
    chk("rw_addr", dm_addr, 0);
    chk("rw_be", dm_be, 0);
    chk("rw_rd", read_data, 0);
    chk("rw_stall", stall_req, 0);
    chk("rw_misalign", misalign, 0);
    chk("rw_bus_err", bus_err, 0);
    idle_inputs();
    tick;
    rst = 1'b1;
    tick;
    chk("rw_after_req", dm_req, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
